spi_frame_feeder: RTL

- Upstream companion to the SPI byte transmitter.
- Buffers bytes pushed by the controller, each tagged with an end-of-frame flag, in a small FIFO.
- Drives the transmitter's chip select and byte input, and advances to the next byte on each transmitter valid pulse.
- Opens a frame only when a complete frame is buffered, so the transmitter never clocks stale data mid-frame.

---
 rtl/spi_frame_feeder_if.sv | 26 ++
 rtl/spi_frame_feeder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spi_frame_feeder_if.sv
// Controller/transmitter-side signal bundle for spi_frame_feeder.
// The master modport belongs to whatever drives writes and transmitter strobes; slave is the feeder.
interface spi_frame_feeder_if;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       wr_en;
    logic       clr_err;
    logic       spi_valid;
    logic [7:0] tx_data;
    logic       cs;
    logic       full;
    logic       empty;
    logic       busy;
    logic       frame_done;
    logic       overflow;

    modport master (
        output wr_data, wr_last, wr_en, clr_err, spi_valid,
        input  tx_data, cs, full, empty, busy, frame_done, overflow
    );

    modport slave (
        input  wr_data, wr_last, wr_en, clr_err, spi_valid,
        output tx_data, cs, full, empty, busy, frame_done, overflow
    );
endinterface

// File: rtl/spi_frame_feeder.sv
// Frame-aware byte FIFO feeding an SPI byte transmitter: a frame is only opened
// once its last byte is buffered, so cs never stays low waiting on the controller.
module spi_frame_feeder #(
    parameter int DEPTH  = 16,
    parameter int CS_GAP = 4
) (
    input  logic              clk,
    input  logic              reset,
    spi_frame_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    typedef enum logic [1:0] {IDLE, LOAD, XFER, GAP} state_t;

    // Storage entries are {last, data}
    logic [8:0]    mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pend_q, pend_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          last_q, last_d;
    logic          cs_q, cs_d;
    logic          done_q, done_d;

    logic [8:0]    head;
    logic          wr_acc;
    logic          pop;
    logic          pend_inc;
    logic          pend_dec;

    assign head   = mem_q[rd_ptr_q];
    assign wr_acc = bus.wr_en && !full_q;

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        done_d    = 1'b0;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_data_d = head[7:0];
                last_d    = head[8];
                pop       = !empty_q;
                state_d   = XFER;
            end
            XFER: begin
                if (bus.spi_valid) begin
                    if (last_q) begin
                        done_d  = 1'b1;
                        gap_d   = '0;
                        state_d = GAP;
                    end else begin
                        // The rest of the frame is already buffered, so the head is valid here
                        tx_data_d = head[7:0];
                        last_d    = head[8];
                        pop       = !empty_q;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cs_d = (state_d != XFER);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        pend_inc = wr_acc && bus.wr_last;
        pend_dec = pop && head[8];
        if (pend_inc && !pend_dec) begin
            pend_d = pend_q + 1'b1;
        end else if (pend_dec && !pend_inc) begin
            pend_d = pend_q - 1'b1;
        end

        // A dropped write wins over a clear in the same cycle
        if (bus.wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (bus.clr_err) begin
            ovf_d = 1'b0;
        end

        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            gap_q     <= '0;
            tx_data_q <= '0;
            last_q    <= 1'b0;
            cs_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
            cs_q      <= cs_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= {bus.wr_last, bus.wr_data};
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.cs         = cs_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = done_q;
    assign bus.overflow   = ovf_q;
endmodule
